// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and select codes for the EX-stage forwarding / load-use hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Destination information of a stage that may write the register file.
  typedef struct packed {
    reg_addr_t rd;
    logic      regwrite;
  } wr_rec_t;

  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    logic      uses_rt;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } ex_rec_t;

  typedef struct packed {
    wr_rec_t wr;
    logic    memread;
  } mem_rec_t;

  localparam ex_rec_t EX_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_unit.sv
// Forwarding select for one ALU operand: newest matching writer wins, $0 never forwards.
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
(
  input  reg_addr_t  src_addr_i,
  input  logic       src_used_i,
  input  wr_rec_t    mem_wr_i,
  input  wr_rec_t    wb_wr_i,
  output logic [1:0] sel_o
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_wr_i.regwrite && (mem_wr_i.rd != '0) && (mem_wr_i.rd == src_addr_i);
    wb_hit  = wb_wr_i.regwrite && (wb_wr_i.rd != '0) && (wb_wr_i.rd == src_addr_i);
    sel_o   = FWD_RF;
    if (src_used_i) begin
      if (mem_hit) begin
        sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX/MEM/WB destination tracking, operand forwarding selects and load-use stall control.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  // Stage records are sized by the package, so this must equal fwd_hazard_ctrl_pkg::REG_AW.
  parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ex_rec_t          ex_q, ex_d;
  mem_rec_t         mem_q, mem_d;
  wr_rec_t          wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  reg_addr_t  src_addr [2];
  logic       src_used [2];
  logic [1:0] sel      [2];

  always_comb begin
    stall_o = ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
              ((ex_q.rd == id_rs_i) || (id_uses_rt_i && (ex_q.rd == id_rt_i)));

    ex_d = EX_BUBBLE;
    if (!(flush_i || stall_o)) begin
      ex_d.rs       = id_rs_i;
      ex_d.rt       = id_rt_i;
      ex_d.uses_rt  = id_uses_rt_i;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
    end

    mem_d.wr.rd       = ex_q.rd;
    mem_d.wr.regwrite = ex_q.regwrite;
    mem_d.memread     = ex_q.memread;
    wb_d              = mem_q.wr;

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= EX_BUBBLE;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Operand A always reads rs; operand B reads rt only when the instruction uses it.
  assign src_addr[0] = ex_q.rs;
  assign src_used[0] = 1'b1;
  assign src_addr[1] = ex_q.rt;
  assign src_used[1] = ex_q.uses_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      fwd_sel_unit u_sel (
        .src_addr_i (src_addr[gi]),
        .src_used_i (src_used[gi]),
        .mem_wr_i   (mem_q.wr),
        .wb_wr_i    (wb_q),
        .sel_o      (sel[gi])
      );
    end
  endgenerate

  assign fwd_a_o     = sel[0];
  assign fwd_b_o     = sel[1];
  assign stall_cnt_o = stall_cnt_q;

  // A load still in MEM has no ALU result to forward; the stall must have kept its consumer out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (!(mem_q.memread && ((fwd_a_o == FWD_EXMEM) || (fwd_b_o == FWD_EXMEM))));
    end
  end

endmodule
